// File: rtl/a2ser_pkg.sv
// Shared constants for the DL11-style serial mux: register offsets, CSR bit positions, default bases/vectors.
package a2ser_pkg;

   localparam logic [21:0] A2SER_BASE0 = 22'o17777560;
   localparam logic [21:0] A2SER_BASEN = 22'o17776500;
   localparam logic [8:0]  A2SER_VEC0  = 9'o060;
   localparam logic [8:0]  A2SER_VECN  = 9'o300;

   // PDP byte offsets from a channel base
   localparam logic [2:0] OFF_RCSR = 3'o0;
   localparam logic [2:0] OFF_RBUF = 3'o2;
   localparam logic [2:0] OFF_XCSR = 3'o4;
   localparam logic [2:0] OFF_XBUF = 3'o6;

   localparam logic [1:0] A2_REG0 = 2'd0;
   localparam logic [1:0] A2_REG1 = 2'd1;
   localparam logic [1:0] A2_REG2 = 2'd2;
   localparam logic [1:0] A2_REG3 = 2'd3;

   localparam int BIT_DONE  = 7;
   localparam int BIT_IE    = 6;
   localparam int BIT_MAINT = 2;
   localparam int BIT_ERR   = 15;
   localparam int BIT_OVR   = 14;

   function automatic logic [21:0] ch_base(input int k, input logic [21:0] base0, input logic [21:0] basen);
      return (k == 0) ? base0 : basen + 22'(8 * (k - 1));
   endfunction

   function automatic logic [8:0] ch_vec(input int k, input logic [8:0] vec0, input logic [8:0] vecn);
      return (k == 0) ? vec0 : vecn + 9'(8 * (k - 1));
   endfunction

endpackage

// File: rtl/a2_serial_mux_if.sv
// Decoded PDP and Apple access pulses into the serial mux, plus the read data coming back.
interface a2_serial_mux_if;
   logic        pdp_req;
   logic        pdp_we;
   logic        pdp_byte;
   logic [21:0] pdp_addr;
   logic [15:0] pdp_wdata;
   logic        pdp_hit;
   logic [15:0] pdp_rdata;
   logic        a2_strobe;
   logic        a2_rw;
   logic [3:0]  a2_addr;
   logic [7:0]  a2_wdata;
   logic [7:0]  a2_rdata;

   modport master (
      output pdp_req, pdp_we, pdp_byte, pdp_addr, pdp_wdata,
      output a2_strobe, a2_rw, a2_addr, a2_wdata,
      input  pdp_hit, pdp_rdata, a2_rdata
   );

   modport slave (
      input  pdp_req, pdp_we, pdp_byte, pdp_addr, pdp_wdata,
      input  a2_strobe, a2_rw, a2_addr, a2_wdata,
      output pdp_hit, pdp_rdata, a2_rdata
   );
endinterface

// File: rtl/a2ser_fifo.sv
// 8-bit synchronous FIFO, head visible combinationally; push when full is dropped unless a pop frees the slot,
// pop when empty is ignored. Flush clears pointers and count in one cycle.
module a2ser_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       i_flush,
   input  logic       i_push,
   input  logic [7:0] i_dat,
   input  logic       i_pop,
   output logic [7:0] o_head,
   output logic       o_empty,
   output logic       o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
   end

   always_ff @(posedge clk) begin
      if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      end
   end
endmodule

// File: rtl/a2_serial_mux.sv
// NCH DL11-style serial lines between the DCJ11 bus and the Apple II slot; PDP reads combinational, Apple reads
// registered, full FIFOs drop pushes. A2SER_LOOPBACK_EN adds XCSR MAINT (XBUF writes loop into the channel's RX).
module a2_serial_mux
   import a2ser_pkg::*;
#(
   parameter int          NCH   = 2,
   parameter int          DEPTH = 16,
   parameter logic [21:0] BASE0 = A2SER_BASE0,
   parameter logic [21:0] BASEN = A2SER_BASEN,
   parameter logic [8:0]  VEC0  = A2SER_VEC0,
   parameter logic [8:0]  VECN  = A2SER_VECN
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           bus_init,
   a2_serial_mux_if.slave bus,
   output logic           irq,
   output logic [8:0]     irq_vec
);
   logic           w_clr;
   logic           w_pdp_req;
   logic           w_pdp_wr;
   logic           w_a2_stb;
   logic [2:0]     w_pdp_off;
   logic [1:0]     w_a2_ch;
   logic [1:0]     w_a2_reg;
   logic [NCH-1:0] w_pdp_sel;
   logic [15:0]    w_pdp_rdata;
   logic [7:0]     w_a2_rd;
   logic [7:0]     r_a2_rdata;

   logic [NCH-1:0] r_ie_rx, r_ie_tx, r_ovr, w_maint;
   logic [NCH-1:0] w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
   logic [NCH-1:0] w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic [7:0]     w_rx_din  [NCH];
   logic [7:0]     w_rx_head [NCH];
   logic [7:0]     w_tx_head [NCH];

   // bus_init/rst win over any access landing in the same cycle
   assign w_clr     = rst | bus_init;
   assign w_pdp_req = bus.pdp_req & ~w_clr;
   assign w_a2_stb  = bus.a2_strobe & ~w_clr;
   assign w_pdp_wr  = bus.pdp_we & (~bus.pdp_byte | ~bus.pdp_addr[0]);
   assign w_pdp_off = {bus.pdp_addr[2:1], 1'b0};
   assign w_a2_ch   = bus.a2_addr[3:2];
   assign w_a2_reg  = bus.a2_addr[1:0];

   always_comb begin
      for (int k = 0; k < NCH; k++)
         w_pdp_sel[k] = ((bus.pdp_addr & ~22'o7) == ch_base(k, BASE0, BASEN));
   end
   assign bus.pdp_hit = |w_pdp_sel;

   always_comb begin
      w_rx_push = '0;
      w_rx_pop  = '0;
      w_tx_push = '0;
      w_tx_pop  = '0;
      for (int k = 0; k < NCH; k++) begin
         w_rx_din[k] = bus.a2_wdata;
         if (w_a2_stb && int'(w_a2_ch) == k) begin
            if (bus.a2_rw && w_a2_reg == A2_REG1)  w_tx_pop[k]  = 1'b1;
            if (!bus.a2_rw && w_a2_reg == A2_REG3) w_rx_push[k] = 1'b1;
         end
         // a loopback write shares the RX push port; it takes the slot over a same-cycle Apple push
         if (w_pdp_req && w_pdp_sel[k]) begin
            if (!bus.pdp_we && w_pdp_off == OFF_RBUF) w_rx_pop[k] = 1'b1;
            if (w_pdp_wr && w_pdp_off == OFF_XBUF) begin
               if (w_maint[k]) begin
                  w_rx_push[k] = 1'b1;
                  w_rx_din[k]  = bus.pdp_wdata[7:0];
               end else begin
                  w_tx_push[k] = 1'b1;
               end
            end
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      a2ser_fifo #(.DEPTH(DEPTH)) u_rx (
         .clk(clk), .i_flush(w_clr), .i_push(w_rx_push[k]), .i_dat(w_rx_din[k]), .i_pop(w_rx_pop[k]),
         .o_head(w_rx_head[k]), .o_empty(w_rx_empty[k]), .o_full(w_rx_full[k])
      );
      a2ser_fifo #(.DEPTH(DEPTH)) u_tx (
         .clk(clk), .i_flush(w_clr), .i_push(w_tx_push[k]), .i_dat(bus.pdp_wdata[7:0]), .i_pop(w_tx_pop[k]),
         .o_head(w_tx_head[k]), .o_empty(w_tx_empty[k]), .o_full(w_tx_full[k])
      );
   end

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_ie_rx <= '0;
         r_ie_tx <= '0;
         r_ovr   <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (w_pdp_req && w_pdp_wr && w_pdp_sel[k]) begin
               if (w_pdp_off == OFF_RCSR) r_ie_rx[k] <= bus.pdp_wdata[BIT_IE];
               if (w_pdp_off == OFF_XCSR) r_ie_tx[k] <= bus.pdp_wdata[BIT_IE];
            end
            // a pop on a full FIFO frees the slot, so a same-cycle push is not an overrun
            if (w_rx_pop[k] && !w_rx_empty[k])      r_ovr[k] <= 1'b0;
            else if (w_rx_push[k] && w_rx_full[k])  r_ovr[k] <= 1'b1;
         end
      end
   end

`ifdef A2SER_LOOPBACK_EN
   logic [NCH-1:0] r_maint;
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_maint <= '0;
      end else begin
         for (int k = 0; k < NCH; k++)
            if (w_pdp_req && w_pdp_wr && w_pdp_sel[k] && w_pdp_off == OFF_XCSR)
               r_maint[k] <= bus.pdp_wdata[BIT_MAINT];
      end
   end
   assign w_maint = r_maint;
`else
   assign w_maint = '0;
`endif

   always_comb begin
      w_pdp_rdata = '0;
      for (int k = 0; k < NCH; k++) begin
         if (w_pdp_sel[k]) begin
            case (w_pdp_off)
               OFF_RCSR: begin
                  w_pdp_rdata[BIT_DONE] = ~w_rx_empty[k];
                  w_pdp_rdata[BIT_IE]   = r_ie_rx[k];
               end
               OFF_RBUF: begin
                  if (!w_rx_empty[k]) begin
                     w_pdp_rdata[7:0]     = w_rx_head[k];
                     w_pdp_rdata[BIT_ERR] = r_ovr[k];
                     w_pdp_rdata[BIT_OVR] = r_ovr[k];
                  end
               end
               OFF_XCSR: begin
                  w_pdp_rdata[BIT_DONE]  = ~w_tx_full[k];
                  w_pdp_rdata[BIT_IE]    = r_ie_tx[k];
                  w_pdp_rdata[BIT_MAINT] = w_maint[k];
               end
               default: w_pdp_rdata = '0;
            endcase
         end
      end
   end
   assign bus.pdp_rdata = w_pdp_rdata;

   always_comb begin
      w_a2_rd = '0;
      for (int k = 0; k < NCH; k++) begin
         if (int'(w_a2_ch) == k) begin
            case (w_a2_reg)
               A2_REG0: w_a2_rd = {~w_tx_empty[k], w_rx_full[k], r_ovr[k], 5'b0};
               A2_REG1: w_a2_rd = w_tx_empty[k] ? 8'h00 : w_tx_head[k];
               A2_REG2: w_a2_rd = {~w_rx_full[k], 7'b0};
               default: w_a2_rd = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_clr)                     r_a2_rdata <= '0;
      else if (w_a2_stb && bus.a2_rw) r_a2_rdata <= w_a2_rd;
   end
   assign bus.a2_rdata = r_a2_rdata;

   // walk from the top so the lowest-numbered source wins
   always_comb begin
      irq     = 1'b0;
      irq_vec = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (r_ie_tx[k] && !w_tx_full[k]) begin
            irq     = 1'b1;
            irq_vec = ch_vec(k, VEC0, VECN) + 9'd4;
         end
         if (r_ie_rx[k] && !w_rx_empty[k]) begin
            irq     = 1'b1;
            irq_vec = ch_vec(k, VEC0, VECN);
         end
      end
   end
endmodule

// File: tb/tb_a2_serial_mux.sv
// Directed bench for a2_serial_mux: queue scoreboards for ch0 RX and ch1 TX, immediate-assert checks.
module tb_a2_serial_mux;
   localparam logic [21:0] RCSR0 = 22'o17777560;
   localparam logic [21:0] RBUF0 = 22'o17777562;
   localparam logic [21:0] XCSR0 = 22'o17777564;
   localparam logic [21:0] XBUF0 = 22'o17777566;
   localparam logic [21:0] RCSR1 = 22'o17776500;
   localparam logic [21:0] XCSR1 = 22'o17776504;
   localparam logic [21:0] XBUF1 = 22'o17776506;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bus_init = 1'b0;
   logic       irq;
   logic [8:0] irq_vec;
   int         n_vec = 0;
   int         n_err = 0;

   logic [7:0] m_rx0[$];
   logic [7:0] m_tx1[$];
   logic       m_ovr0 = 1'b0;

   a2_serial_mux_if bus_if ();

   a2_serial_mux u_dut (
      .clk(clk), .rst(rst), .bus_init(bus_init), .bus(bus_if), .irq(irq), .irq_vec(irq_vec)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pdp_wr(input logic [21:0] a, input logic [15:0] d, input logic b);
      @(negedge clk);
      bus_if.pdp_addr = a; bus_if.pdp_wdata = d; bus_if.pdp_we = 1'b1; bus_if.pdp_byte = b;
      bus_if.pdp_req = 1'b1;
      @(negedge clk);
      bus_if.pdp_req = 1'b0; bus_if.pdp_we = 1'b0; bus_if.pdp_byte = 1'b0;
   endtask

   task automatic pdp_rd(input logic [21:0] a, output logic [15:0] d);
      @(negedge clk);
      bus_if.pdp_addr = a; bus_if.pdp_we = 1'b0; bus_if.pdp_byte = 1'b0; bus_if.pdp_req = 1'b1;
      #1 d = bus_if.pdp_rdata;
      @(negedge clk);
      bus_if.pdp_req = 1'b0;
   endtask

   task automatic a2_wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      bus_if.a2_addr = a; bus_if.a2_wdata = d; bus_if.a2_rw = 1'b0; bus_if.a2_strobe = 1'b1;
      @(negedge clk);
      bus_if.a2_strobe = 1'b0;
   endtask

   task automatic a2_rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      bus_if.a2_addr = a; bus_if.a2_rw = 1'b1; bus_if.a2_strobe = 1'b1;
      @(negedge clk);
      bus_if.a2_strobe = 1'b0;
      d = bus_if.a2_rdata;
   endtask

   task automatic push0(input logic [7:0] b);
      a2_wr(4'h3, b);
      if (m_rx0.size() < 16) m_rx0.push_back(b);
      else m_ovr0 = 1'b1;
   endtask

   task automatic rbuf0(input string tag);
      logic [15:0] d, e;
      e = (m_rx0.size() != 0) ? {m_ovr0, m_ovr0, 6'b0, m_rx0[0]} : 16'h0000;
      pdp_rd(RBUF0, d);
      chk(tag, d, e);
      if (m_rx0.size() != 0) begin
         void'(m_rx0.pop_front());
         m_ovr0 = 1'b0;
      end
   endtask

   task automatic xbuf1(input logic [7:0] b);
      pdp_wr(XBUF1, {8'h00, b}, 1'b0);
      if (m_tx1.size() < 16) m_tx1.push_back(b);
   endtask

   task automatic txpop1(input string tag);
      logic [7:0] d, e;
      e = (m_tx1.size() != 0) ? m_tx1.pop_front() : 8'h00;
      a2_rd(4'h5, d);
      chk(tag, {8'h00, d}, {8'h00, e});
   endtask

   task automatic chk_pdp(input string tag, input logic [21:0] a, input logic [15:0] e);
      logic [15:0] d;
      pdp_rd(a, d);
      chk(tag, d, e);
   endtask

   task automatic chk_a2(input string tag, input logic [3:0] a, input logic [7:0] e);
      logic [7:0] d;
      a2_rd(a, d);
      chk(tag, {8'h00, d}, {8'h00, e});
   endtask

   task automatic chk_irq(input string tag, input logic e_irq, input logic [8:0] e_vec);
      chk({tag, "_irq"}, {15'b0, irq}, {15'b0, e_irq});
      chk({tag, "_vec"}, {7'b0, irq_vec}, {7'b0, e_vec});
   endtask

   initial begin
      logic [15:0] d16;
      bus_if.pdp_req = 1'b0; bus_if.pdp_we = 1'b0; bus_if.pdp_byte = 1'b0;
      bus_if.pdp_addr = '0; bus_if.pdp_wdata = '0;
      bus_if.a2_strobe = 1'b0; bus_if.a2_rw = 1'b0; bus_if.a2_addr = '0; bus_if.a2_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state and decode
      chk_irq("reset", 1'b0, 9'd0);
      chk("reset_a2_rdata", {8'h00, bus_if.a2_rdata}, 16'h0000);
      bus_if.pdp_addr = RCSR0;
      #1 chk("hit_ch0", {15'b0, bus_if.pdp_hit}, 16'h0001);
      bus_if.pdp_addr = 22'o17777570;
      #1 chk("miss_hit", {15'b0, bus_if.pdp_hit}, 16'h0000);
      chk("miss_rdata", bus_if.pdp_rdata, 16'h0000);
      chk_pdp("reset_rcsr0", RCSR0, 16'h0000);
      chk_pdp("reset_xcsr0", XCSR0, 16'h0080);
      chk_pdp("reset_xcsr1", XCSR1, 16'h0080);

      // Apple -> PDP basic path
      push0(8'h41);
      push0(8'h42);
      chk_pdp("rcsr0_done", RCSR0, 16'h0080);
      rbuf0("rbuf_A");
      rbuf0("rbuf_B");
      chk_pdp("rcsr0_empty", RCSR0, 16'h0000);
      rbuf0("rbuf_empty");

      // PDP -> Apple, fill past depth
      for (int i = 1; i <= 17; i++) begin
         xbuf1(8'(i));
         if (i == 15) chk_pdp("xcsr1_ready15", XCSR1, 16'h0080);
         if (i == 16) chk_pdp("xcsr1_full16", XCSR1, 16'h0000);
      end
      chk_a2("a2_reg0_ch1", 4'h4, 8'h80);
      for (int i = 1; i <= 17; i++) txpop1("tx1_pop");
      chk_pdp("xcsr1_drained", XCSR1, 16'h0080);

      // RX overrun
      for (int i = 0; i < 17; i++) push0(8'(8'h10 + i));
      chk_a2("a2_reg0_ovr", 4'h0, 8'h60);
      chk_a2("a2_reg2_full", 4'h2, 8'h00);
      rbuf0("rbuf_ovr");
      rbuf0("rbuf_after_ovr");
      for (int i = 0; i < 15; i++) rbuf0("rbuf_drain");

      // interrupt priority
      pdp_wr(RCSR0, 16'h0040, 1'b0);
      pdp_wr(XCSR1, 16'h0040, 1'b0);
      chk_irq("tx1_only", 1'b1, 9'o304);
      push0(8'h55);
      chk_irq("rx0_wins", 1'b1, 9'o060);
      chk_pdp("rcsr0_ie_done", RCSR0, 16'h00C0);
      rbuf0("rbuf_55");
      chk_irq("rx0_drained", 1'b1, 9'o304);

      // same-cycle Apple push and PDP pop
      push0(8'h61);
      push0(8'h62);
      push0(8'h63);
      @(negedge clk);
      bus_if.pdp_addr = RBUF0; bus_if.pdp_we = 1'b0; bus_if.pdp_byte = 1'b0; bus_if.pdp_req = 1'b1;
      bus_if.a2_addr = 4'h3; bus_if.a2_rw = 1'b0; bus_if.a2_wdata = 8'h64; bus_if.a2_strobe = 1'b1;
      #1 d16 = bus_if.pdp_rdata;
      @(negedge clk);
      bus_if.pdp_req = 1'b0; bus_if.a2_strobe = 1'b0;
      chk("simul_rbuf", d16, {m_ovr0, m_ovr0, 6'b0, m_rx0[0]});
      void'(m_rx0.pop_front());
      m_rx0.push_back(8'h64);
      for (int i = 0; i < 4; i++) rbuf0("rbuf_simul_order");

      // bus_init flush with a colliding XBUF write and Apple push
      push0(8'h71);
      push0(8'h72);
      xbuf1(8'h81);
      chk_irq("pre_init", 1'b1, 9'o060);
      chk_a2("a2_reg2_notfull", 4'h2, 8'h80);
      @(negedge clk);
      bus_init = 1'b1;
      bus_if.pdp_addr = XBUF0; bus_if.pdp_wdata = 16'h0077; bus_if.pdp_we = 1'b1; bus_if.pdp_req = 1'b1;
      bus_if.a2_addr = 4'h7; bus_if.a2_rw = 1'b0; bus_if.a2_wdata = 8'h99; bus_if.a2_strobe = 1'b1;
      @(negedge clk);
      bus_init = 1'b0; bus_if.pdp_req = 1'b0; bus_if.pdp_we = 1'b0; bus_if.a2_strobe = 1'b0;
      m_rx0.delete();
      m_tx1.delete();
      m_ovr0 = 1'b0;
      chk("init_a2_rdata", {8'h00, bus_if.a2_rdata}, 16'h0000);
      chk_irq("post_init", 1'b0, 9'd0);
      chk_pdp("init_rcsr0", RCSR0, 16'h0000);
      chk_pdp("init_rcsr1", RCSR1, 16'h0000);
      chk_pdp("init_xcsr1", XCSR1, 16'h0080);
      chk_a2("init_tx0_pop", 4'h1, 8'h00);
      txpop1("init_tx1_pop");
      rbuf0("init_rbuf0");

      // byte-write qualification and out-of-range Apple channel
      pdp_wr(22'o17777561, 16'h4040, 1'b1);
      chk_pdp("odd_byte_ignored", RCSR0, 16'h0000);
      pdp_wr(RCSR0, 16'h0040, 1'b1);
      chk_pdp("even_byte_ie", RCSR0, 16'h0040);
      pdp_wr(22'o17777567, 16'h4141, 1'b1);
      chk_a2("odd_xbuf_ignored", 4'h1, 8'h00);
      a2_wr(4'hB, 8'h12);
      chk_a2("ch2_reg0", 4'h8, 8'h00);
      chk_a2("ch0_no_alias", 4'h0, 8'h00);
      chk_irq("final", 1'b0, 9'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
